// File: rtl/zint_pkg.sv
// Shared definitions for the Z80 maskable-interrupt controller (zint_ctl).
// Holds the FSM state type, source-index width and vector-base reset value.
package zint_pkg;

  localparam int unsigned ZINT_NSRC_MAX = 4;
  localparam int unsigned ZINT_IDX_W    = $clog2(ZINT_NSRC_MAX);
  localparam logic [7:0]  ZINT_VBASE_RST = 8'hF8;

  typedef enum logic [1:0] {
    IDLE,
    ASSERT,
    ACK,
    GAP
  } zint_state_e;

endpackage

// File: rtl/zint_prio_enc.sv
// Combinational fixed-priority encoder: returns the lowest set request index
// (index 0 = highest priority) plus a valid flag.
module zint_prio_enc
  import zint_pkg::*;
#(
  parameter int unsigned NSRC = 3
) (
  input  logic [NSRC-1:0]       req,
  output logic [ZINT_IDX_W-1:0] idx,
  output logic                  valid
);

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (req[i] && !valid) begin
        idx   = ZINT_IDX_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/zint_ctl.sv
// Z80 maskable-interrupt controller: pending/mask latching, fixed-priority
// selection, bounded /INT pulse, INTACK detection. IM2 vector support is
// compiled in with `define ZINT_CTL_VECTOR_EN; otherwise vec=8'hFF, vec_oe=0.
module zint_ctl
  import zint_pkg::*;
#(
  parameter int unsigned NSRC      = 3,
  parameter int unsigned PULSE_LEN = 128
) (
  input  logic            fclk,
  input  logic            rst_n,
  input  logic            zneg,
  input  logic            iorq_n,
  input  logic            m1_n,
  input  logic [NSRC-1:0] src_stb,
  input  logic            mask_we,
  input  logic [NSRC-1:0] mask_d,
  input  logic            vbase_we,
  input  logic [7:0]      vbase_d,
  output logic            int_n,
  output logic            vec_oe,
  output logic [7:0]      vec,
  output logic [NSRC-1:0] pend,
  output logic [NSRC-1:0] missed
);

  localparam logic [7:0] CNT_LAST = 8'(PULSE_LEN - 1);

  zint_state_e           state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [ZINT_IDX_W-1:0] cur_q, cur_d;
  logic [ZINT_IDX_W-1:0] enc_idx;
  logic                  enc_valid;
  logic [NSRC-1:0]       mask_q, pend_q, missed_q, req, cur_bits;
  logic                  ack, clr_cur, set_miss;

  assign ack      = !iorq_n && !m1_n && zneg;
  assign req      = pend_q & mask_q;
  assign cur_bits = NSRC'(1) << cur_q;
  assign pend     = pend_q;
  assign missed   = missed_q;

  zint_prio_enc #(.NSRC(NSRC)) u_prio (
    .req   (req),
    .idx   (enc_idx),
    .valid (enc_valid)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cur_d    = cur_q;
    clr_cur  = 1'b0;
    set_miss = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enc_valid) begin
          cur_d   = enc_idx;
          cnt_d   = '0;
          state_d = ASSERT;
        end
      end
      ASSERT: begin
        // Mask is deliberately ignored here: a started pulse always completes.
        cnt_d = cnt_q + 8'd1;
        if (ack) begin
          clr_cur = 1'b1;
          state_d = ACK;
        end else if (cnt_q == CNT_LAST) begin
          clr_cur  = 1'b1;
          set_miss = 1'b1;
          state_d  = GAP;
        end
      end
      ACK: begin
        if (iorq_n) state_d = GAP;
      end
      GAP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cur_q   <= '0;
      int_n   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cur_q   <= cur_d;
      int_n   <= (state_d != ASSERT);
    end
  end

  // New strobes are OR-ed in after the clear so a coincident event survives.
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q   <= '0;
      missed_q <= '0;
      mask_q   <= '1;
    end else begin
      pend_q   <= (pend_q & ~(clr_cur ? cur_bits : '0)) | src_stb;
      missed_q <= (mask_we ? '0 : missed_q) | (set_miss ? cur_bits : '0);
      if (mask_we) mask_q <= mask_d;
    end
  end

`ifdef ZINT_CTL_VECTOR_EN
  logic [4:0] vbase_q;
  logic       unused_vbase_lsb;

  assign unused_vbase_lsb = ^vbase_d[2:0];

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      vbase_q <= ZINT_VBASE_RST[7:3];
      vec     <= {ZINT_VBASE_RST[7:3], 3'b000};
      vec_oe  <= 1'b0;
    end else begin
      if (vbase_we) vbase_q <= vbase_d[7:3];
      vec    <= {vbase_q, 2'(cur_q), 1'b0};
      vec_oe <= (state_d == ACK) && !iorq_n && !m1_n;
    end
  end
`else
  logic unused_vbase;

  assign unused_vbase = ^{vbase_we, vbase_d};
  assign vec          = 8'hFF;
  assign vec_oe       = 1'b0;
`endif

endmodule

// File: tb/tb_zint_ctl.sv
// Randomized scoreboard bench for zint_ctl: a transaction-level model predicts
// each /INT pulse (length, pend/missed afterwards); a monitor checks pulses.
module tb_zint_ctl;

  localparam int NSRC = 3;
  localparam int PLEN = 128;

  logic            fclk = 1'b0;
  logic            rst_n = 1'b0;
  logic            zneg = 1'b0, iorq_n = 1'b1, m1_n = 1'b1;
  logic [NSRC-1:0] src_stb = '0, mask_d = '0;
  logic            mask_we = 1'b0, vbase_we = 1'b0;
  logic [7:0]      vbase_d = 8'h00;
  logic            int_n, vec_oe;
  logic [7:0]      vec;
  logic [NSRC-1:0] pend, missed;

  zint_ctl #(.NSRC(NSRC), .PULSE_LEN(PLEN)) dut (
    .fclk(fclk), .rst_n(rst_n), .zneg(zneg), .iorq_n(iorq_n), .m1_n(m1_n),
    .src_stb(src_stb), .mask_we(mask_we), .mask_d(mask_d),
    .vbase_we(vbase_we), .vbase_d(vbase_d),
    .int_n(int_n), .vec_oe(vec_oe), .vec(vec), .pend(pend), .missed(missed)
  );

  always #5 fclk = ~fclk;

  typedef struct {
    int              len;
    logic [NSRC-1:0] pend;
    logic [NSRC-1:0] missed;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   lowcnt = 0;
  int   force_d = -1;

  // Reference state: what the controller should hold between transactions.
  logic [NSRC-1:0] m_pend = '0, m_mask = '1, m_missed = '0;
  logic [7:0]      m_vbase = 8'hF8;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic finish_now();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  // Monitor: a pulse ends when int_n returns high; compare against the queue.
  always @(negedge fclk) begin
    if (!rst_n) lowcnt = 0;
    else if (!int_n) lowcnt++;
    else if (lowcnt > 0) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got pulse of %0d cycles, expected none", lowcnt);
      end else begin
        mon_e = sbq.pop_front();
        chk("pulse_len", lowcnt, mon_e.len);
        chk("pend_after", 32'(pend), 32'(mon_e.pend));
        chk("missed_after", 32'(missed), 32'(mon_e.missed));
      end
      lowcnt = 0;
    end
  end

  initial begin
    #900000;
    checks++;
    errors++;
    $display("FAIL watchdog: got no end of test, expected finish");
    finish_now();
  end

  task automatic wait_low(input int start, output int n);
    bit ok = 0;
    n = start;
    for (int i = 0; i < 40; i++) begin
      @(negedge fclk);
      n++;
      if (!int_n) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL int_low_timeout: got int_n=1 after 40 cycles, expected 0");
      finish_now();
    end
  endtask

  task automatic wait_high();
    for (int i = 0; i < 300; i++) begin
      @(negedge fclk);
      zneg   = 1'($urandom);
      iorq_n = 1'($urandom);
      if (int_n) begin
        zneg = 1'b0; iorq_n = 1'b1;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL int_high_timeout: got int_n=0 after 300 cycles, expected 1");
    finish_now();
  endtask

  // Serve every enabled pending source; trigger was applied 'elapsed' negedges ago.
  task automatic service_all(input int elapsed);
    bit first = 1;
    while ((m_pend & m_mask) != '0) begin
      int src = 0;
      int d, n;
      logic [NSRC-1:0] bitv, r;
      exp_t e;
      for (int i = NSRC - 1; i >= 0; i--) if ((m_pend & m_mask) & (NSRC'(1) << i)) src = i;
      bitv = NSRC'(1) << src;
      if (force_d >= 0) d = force_d;
      else case ($urandom_range(0, 7))
        0: d = 0;
        1: d = PLEN - 1;
        2: d = PLEN;
        default: d = $urandom_range(1, 40);
      endcase
      r = ($urandom_range(0, 3) == 0) ? NSRC'($urandom) : '0;
      if (d < PLEN) begin
        m_pend = (m_pend & ~bitv) | r;
        e.len  = d + 1;
      end else begin
        m_pend   = m_pend & ~bitv;
        m_missed = m_missed | bitv;
        e.len    = PLEN;
        r        = '0;
      end
      e.pend   = m_pend;
      e.missed = m_missed;
      sbq.push_back(e);

      wait_low(first ? elapsed : 0, n);
      if (first) chk("latency", n, 2);
      first = 0;

      if (d < PLEN) begin
        for (int k = 0; k < d; k++) begin
          @(negedge fclk);
          zneg = 1'($urandom); iorq_n = 1'($urandom); m1_n = 1'b1;
        end
        iorq_n = 1'b0; m1_n = 1'b0; zneg = 1'b1; src_stb = r;
        @(negedge fclk);
        zneg = 1'b0; src_stb = '0;
`ifdef ZINT_CTL_VECTOR_EN
        chk("vec_oe_ack", 32'(vec_oe), 1);
        chk("vec", 32'(vec), {24'h0, m_vbase[7:3], 2'(src), 1'b0});
`else
        chk("vec_oe_ack", 32'(vec_oe), 0);
        chk("vec", 32'(vec), 32'hFF);
`endif
        @(negedge fclk);
        iorq_n = 1'b1; m1_n = 1'b1;
        @(negedge fclk);
        chk("vec_oe_off", 32'(vec_oe), 0);
      end else begin
        wait_high();
      end
    end
    repeat (2) @(negedge fclk);
  endtask

  task automatic do_mask(input logic [NSRC-1:0] m);
    mask_d = m; mask_we = 1'b1;
    @(negedge fclk);
    mask_we = 1'b0;
    m_mask = m; m_missed = '0;
    service_all(1);
    chk("idle_int_n", 32'(int_n), 1);
    chk("idle_pend", 32'(pend), 32'(m_pend));
  endtask

  task automatic do_strobe(input logic [NSRC-1:0] s);
    src_stb = s;
    @(negedge fclk);
    src_stb = '0;
    m_pend = m_pend | s;
    service_all(1);
    chk("idle_int_n", 32'(int_n), 1);
    chk("idle_pend", 32'(pend), 32'(m_pend));
  endtask

  task automatic do_vbase(input logic [7:0] v);
    vbase_d = v; vbase_we = 1'b1;
    @(negedge fclk);
    vbase_we = 1'b0;
    m_vbase = v;
  endtask

  initial begin
    int n;
    #12;
    chk("rst_int_n", 32'(int_n), 1);
    chk("rst_vec_oe", 32'(vec_oe), 0);
    chk("rst_pend", 32'(pend), 0);
    chk("rst_missed", 32'(missed), 0);
    @(negedge fclk);
    rst_n = 1'b1;
    repeat (2) @(negedge fclk);

    // Directed: timeout, priority, masking.
    force_d = PLEN;
    do_strobe(3'b001);
    force_d = 20;
    do_strobe(3'b001);
    force_d = -1;
    do_vbase(8'hE0);
    do_strobe(3'b110);
    do_mask(3'b110);
    do_strobe(3'b001);
    do_mask(3'b111);

    for (int t = 0; t < 30; t++) begin
      if ($urandom_range(0, 2) == 0) do_vbase(8'($urandom));
      if ($urandom_range(0, 2) == 0) do_mask(($urandom_range(0, 1) == 0) ? 3'b111 : 3'($urandom));
      do_strobe(3'($urandom_range(1, 7)));
    end

    // Reset in the middle of a pulse.
    do_mask(3'b111);
    force_d = PLEN;
    do_strobe(3'b100);
    force_d = -1;
    src_stb = 3'b010;
    @(negedge fclk);
    src_stb = '0;
    wait_low(1, n);
    repeat (5) @(negedge fclk);
    @(posedge fclk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_int_n", 32'(int_n), 1);
    chk("midrst_pend", 32'(pend), 0);
    chk("midrst_missed", 32'(missed), 0);
    chk("midrst_vec_oe", 32'(vec_oe), 0);
    m_pend = '0; m_missed = '0; m_mask = '1; m_vbase = 8'hF8;
    repeat (2) @(negedge fclk);
    rst_n = 1'b1;
    @(negedge fclk);
    chk("post_rst_int_n", 32'(int_n), 1);
    for (int t = 0; t < 6; t++) do_strobe(3'($urandom_range(1, 7)));

    repeat (4) @(negedge fclk);
    chk("final_pend", 32'(pend), 32'(m_pend));
    chk("final_missed", 32'(missed), 32'(m_missed));
    chk("sb_empty", sbq.size(), 0);
    finish_now();
  end

endmodule
